// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scanner.
package seg_pkg;
    localparam int REFRESH_DIV_DEF = 100000;
    localparam int NUM_DIGITS      = 4;
    localparam int IDX_W           = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-low {g,f,e,d,c,b,a} hex glyph decode (b and d lowercase).
// Purely combinational, zero latency.
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);
    always_comb begin
        seg_n = 7'b1111111;
        case (hex)
            4'h0: seg_n = 7'b1000000;
            4'h1: seg_n = 7'b1111001;
            4'h2: seg_n = 7'b0100100;
            4'h3: seg_n = 7'b0110000;
            4'h4: seg_n = 7'b0011001;
            4'h5: seg_n = 7'b0010010;
            4'h6: seg_n = 7'b0000010;
            4'h7: seg_n = 7'b1111000;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0010000;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b0000011;
            4'hC: seg_n = 7'b1000110;
            4'hD: seg_n = 7'b0100001;
            4'hE: seg_n = 7'b0000110;
            4'hF: seg_n = 7'b0001110;
            default: seg_n = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit scan controller: prescaled digit rotation, double-buffered display value
// committed only at frame boundaries, live leading-zero blanking, sticky overrun flag.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    output logic        ready,
    input  logic        blank_lz,
    output logic [1:0]  an_idx,
    output logic [6:0]  seg_n,
    output logic        overrun
);
    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("seg_scan_ctrl: REFRESH_DIV must be at least 2");
    end

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [15:0]      disp;
    logic [15:0]      pend;
    logic             pend_vld;
    logic             tick;
    logic             frame;
    logic             blank;
    logic [3:0]       nibble;
    logic [6:0]       glyph;

    assign tick  = (cnt == CNT_MAX);
    assign frame = tick && (an_idx == 2'd3);

    // Accept and commit are mutually exclusive: accept needs ready, commit needs
    // pend_vld, and ready is low exactly while pend_vld is set. A load accepted on a
    // boundary cycle therefore waits for the next boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            an_idx   <= 2'd0;
            disp     <= 16'h0000;
            pend     <= 16'h0000;
            pend_vld <= 1'b0;
            ready    <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
            if (tick) begin
                an_idx <= an_idx + 2'd1;
            end
            if (load && ready) begin
                pend     <= value;
                pend_vld <= 1'b1;
                ready    <= 1'b0;
            end else if (frame && pend_vld) begin
                disp     <= pend;
                pend_vld <= 1'b0;
                ready    <= 1'b1;
            end
            if (load && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

    assign nibble = disp[{an_idx, 2'b00} +: 4];

    // Digit i is a leading zero when nibbles i..3 are all zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        case (an_idx)
            2'd1:    blank = (disp[15:4]  == 12'h000);
            2'd2:    blank = (disp[15:8]  == 8'h00);
            2'd3:    blank = (disp[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end

    hex_to_seg7 u_dec (
        .hex   (nibble),
        .seg_n (glyph)
    );

    assign seg_n = (blank_lz && blank) ? SEG_BLANK : glyph;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed scenarios for seg_scan_ctrl with REFRESH_DIV=4; expectations are queued by
// cycle and checked by an independent monitor shortly after each falling edge.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        ready;
    logic        blank_lz;
    logic [1:0]  an_idx;
    logic [6:0]  seg_n;
    logic        overrun;

    localparam int SIG_IDX = 0, SIG_SEG = 1, SIG_RDY = 2, SIG_OVR = 3;

    typedef struct {
        int         at;
        int         sig;
        logic [6:0] val;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    seg_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .ready    (ready),
        .blank_lz (blank_lz),
        .an_idx   (an_idx),
        .seg_n    (seg_n),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation for the falling edge k cycles after the last reset release.
    task automatic expect_at(input int k, input int sig, input logic [6:0] val, input string nm);
        exp_t e;
        int   pos;
        e.at  = base + k;
        e.sig = sig;
        e.val = val;
        e.nm  = nm;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].at > e.at) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, e);
    endtask

    task automatic go(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    // Monitor: compares every expectation whose cycle has arrived.
    initial begin
        logic [6:0] act;
        forever begin
            @(negedge clk);
            #2;
            while (q.size() > 0 && q[0].at <= cyc) begin
                exp_t e;
                e = q.pop_front();
                case (e.sig)
                    SIG_IDX: act = {5'b0, an_idx};
                    SIG_SEG: act = seg_n;
                    SIG_RDY: act = {6'b0, ready};
                    default: act = {6'b0, overrun};
                endcase
                n_cmp++;
                if (act !== e.val) begin
                    n_bad++;
                    $display("FAIL %s (cycle %0d): got %b, expected %b", e.nm, cyc - base, act, e.val);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: stimulus did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; value = 16'h0000; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        base = cyc;
        expect_at(0, SIG_IDX, 7'd0, "rst_idx");
        expect_at(0, SIG_SEG, 7'b1000000, "rst_seg");
        expect_at(0, SIG_RDY, 7'd1, "rst_ready");
        expect_at(0, SIG_OVR, 7'd0, "rst_overrun");
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;

        // Scan: slot changes every 4 cycles, display stays 0.
        expect_at(0,  SIG_IDX, 7'd0, "scan_idx_k0");
        expect_at(3,  SIG_IDX, 7'd0, "scan_idx_k3");
        expect_at(4,  SIG_IDX, 7'd1, "scan_idx_k4");
        expect_at(7,  SIG_IDX, 7'd1, "scan_idx_k7");
        expect_at(8,  SIG_IDX, 7'd2, "scan_idx_k8");
        expect_at(12, SIG_IDX, 7'd3, "scan_idx_k12");
        expect_at(15, SIG_IDX, 7'd3, "scan_idx_k15");
        expect_at(16, SIG_IDX, 7'd0, "scan_idx_wrap");
        expect_at(5,  SIG_SEG, 7'b1000000, "scan_seg_d1");
        expect_at(13, SIG_SEG, 7'b1000000, "scan_seg_d3");

        // Load 8F03, then an overrun load of 1234 while pending.
        go(18);
        expect_at(18, SIG_RDY, 7'd1, "load_ready_before");
        load = 1'b1; value = 16'h8F03;
        go(19);
        load = 1'b0;
        expect_at(19, SIG_RDY, 7'd0, "load_ready_low");
        go(20);
        expect_at(20, SIG_OVR, 7'd0, "ovr_before");
        load = 1'b1; value = 16'h1234;
        go(21);
        load = 1'b0;
        expect_at(21, SIG_OVR, 7'd1, "ovr_set");
        expect_at(28, SIG_SEG, 7'b1000000, "no_tear_d3");
        expect_at(31, SIG_RDY, 7'd0, "ready_until_boundary");
        expect_at(32, SIG_RDY, 7'd1, "ready_after_commit");
        expect_at(32, SIG_SEG, 7'b0110000, "disp_d0_3");
        expect_at(36, SIG_SEG, 7'b1000000, "disp_d1_0");
        expect_at(40, SIG_SEG, 7'b0001110, "disp_d2_F");
        expect_at(44, SIG_SEG, 7'b0000000, "disp_d3_8");
        expect_at(44, SIG_OVR, 7'd1, "ovr_sticky");

        // Blanking with 0050.
        go(48);
        load = 1'b1; value = 16'h0050;
        go(49);
        load = 1'b0;
        go(64);
        blank_lz = 1'b1;
        expect_at(64, SIG_SEG, 7'b1000000, "blank_d0_0");
        expect_at(68, SIG_SEG, 7'b0010010, "blank_d1_5");
        expect_at(72, SIG_SEG, 7'b1111111, "blank_d2");
        expect_at(76, SIG_SEG, 7'b1111111, "blank_d3");
        go(77);
        blank_lz = 1'b0;
        expect_at(77, SIG_SEG, 7'b1000000, "blank_live_off");
        go(78);
        blank_lz = 1'b1;
        expect_at(78, SIG_SEG, 7'b1111111, "blank_live_on");

        // Load of 0000 offered in the boundary tick cycle commits a frame later.
        go(79);
        expect_at(79, SIG_IDX, 7'd3, "coin_idx");
        load = 1'b1; value = 16'h0000;
        go(80);
        load = 1'b0;
        expect_at(80, SIG_RDY, 7'd0, "coin_ready_low");
        expect_at(84, SIG_SEG, 7'b0010010, "coin_old_d1");
        expect_at(95, SIG_RDY, 7'd0, "coin_not_yet");
        expect_at(96, SIG_RDY, 7'd1, "coin_committed");
        expect_at(96, SIG_SEG, 7'b1000000, "zero_d0_lit");
        expect_at(100, SIG_SEG, 7'b1111111, "zero_d1_blank");
        expect_at(104, SIG_SEG, 7'b1111111, "zero_d2_blank");
        expect_at(108, SIG_SEG, 7'b1111111, "zero_d3_blank");

        // Mid-frame reset with a pending 1111.
        go(110);
        blank_lz = 1'b0;
        go(112);
        load = 1'b1; value = 16'h1111;
        go(113);
        load = 1'b0;
        expect_at(113, SIG_RDY, 7'd0, "pend_ready_low");
        go(120);
        expect_at(120, SIG_OVR, 7'd1, "ovr_before_reset");
        rst_n = 1'b0;
        go(121);
        rst_n = 1'b1;
        base = cyc;
        expect_at(0, SIG_IDX, 7'd0, "mrst_idx");
        expect_at(0, SIG_RDY, 7'd1, "mrst_ready");
        expect_at(0, SIG_OVR, 7'd0, "mrst_overrun");
        expect_at(0, SIG_SEG, 7'b1000000, "mrst_seg");
        expect_at(3, SIG_IDX, 7'd0, "mrst_no_early_tick");
        expect_at(4, SIG_IDX, 7'd1, "mrst_first_tick");
        expect_at(16, SIG_SEG, 7'b1000000, "mrst_d0_not_pending");
        expect_at(20, SIG_SEG, 7'b1000000, "mrst_d1_not_pending");
        expect_at(20, SIG_RDY, 7'd1, "mrst_ready_hold");
        go(24);
        repeat (3) @(negedge clk);

        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL unchecked: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot; legal range 2 and above, with an elaboration-time check.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port load, input, 1 bit: offer of a new display value.
REQ-005 SHALL have port value, input, 16 bits: four hex nibbles; bits 3:0 are digit 0 (rightmost).
REQ-006 SHALL have port ready, output, 1 bit: high when a load will be accepted.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-008 SHALL have port an_idx, output, 2 bits: active digit index, fed to the downstream anode converter.
REQ-009 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a} for the active digit.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when a load was offered while ready was low.

Function
REQ-011 SHALL run a prescaler counting 0 to REFRESH_DIV-1, then wrap to 0; tick is asserted in the cycle count equals REFRESH_DIV-1.
REQ-012 SHALL advance an_idx by 1 on each tick, wrapping 3 to 0; an_idx is held between ticks.
REQ-013 SHALL define the frame boundary as a tick while an_idx equals 3.
REQ-014 SHALL capture value into a pending register when load and ready are both high; ready goes low the next cycle.
REQ-015 SHALL ignore load while ready is low, set overrun the next cycle, and leave pending unchanged.
REQ-016 SHALL, at a frame boundary with pending valid, copy pending into the display register and raise ready the next cycle; this prevents tearing within a frame.
REQ-017 SHALL commit a value accepted in the same cycle as a frame boundary at the following boundary, not the current one.
REQ-018 SHALL select nibble an_idx of the display register and decode it combinationally to seg_n, with zero latency relative to an_idx.
REQ-019 SHALL use these hex encodings: 0 is 7'b1000000, 8 is 7'b0000000, F is 7'b0001110; all 16 codes follow standard hex glyphs (b and d lowercase).
REQ-020 SHALL, with blank_lz high, drive seg_n to 7'b1111111 for digit i (i from 1 to 3) when the display nibbles i through 3 are all zero; digit 0 is never blanked.
REQ-021 SHALL sample blank_lz live, without latching; it takes effect immediately.

Reset
REQ-022 SHALL, while rst_n is low at a clock edge, set: prescaler 0, an_idx 0, display register 16'h0000, pending invalid, ready 1, overrun 0.
REQ-023 SHALL discard any pending value on reset asserted mid-frame; the first tick after release occurs REFRESH_DIV cycles later.
REQ-024 SHALL give seg_n after reset the value 7'b1000000 (digit 0 showing 0), or all ones if blank_lz is high and the digit is not digit 0.

Structure
REQ-025 SHALL place REFRESH_DIV default, NUM_DIGITS=4, SEG_BLANK=7'b1111111 and the digit index width in shared package seg_pkg.
REQ-026 SHALL implement the nibble-to-segment decode as sub-module hex_to_seg7 (4-bit in, 7-bit active-low out).
REQ-027 SHALL be the upstream stage of the anode converter: an_idx connects directly to it, with no extra register between them.

Verification (REFRESH_DIV=4)
REQ-028 Scan: reset release, no load -> an_idx sequence 0,1,2,3,0 changing every 4 cycles; seg_n stays 7'b1000000.
REQ-029 Load: load=1, value=16'h8F03 while ready=1 -> ready low next cycle; after the next an_idx 3 to 0 tick the digits read 3,0,F,8 and ready returns high.
REQ-030 Overrun: second load 16'h1234 while ready=0 -> overrun=1, display still commits 16'h8F03, and overrun stays set until reset.
REQ-031 Blanking: value 16'h0050, blank_lz=1 -> digits 3 and 2 give 7'b1111111, digit 1 shows 5, digit 0 shows 0; with value 16'h0000 only digit 0 is lit.
REQ-032 Boundary coincidence: load asserted in the frame-boundary tick cycle -> value appears one full frame (16 cycles) later.
REQ-033 Mid-frame reset: rst_n low for 1 cycle while pending is valid -> all REQ-022 values restored and the pending value is never displayed.
